// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use bubble insertion,
// flush/hold handling and a saturating count of inserted load-use bubbles.
module id_ex_operand_stage #(
    parameter int                DATA_W          = 16,
    parameter int                RADDR_W         = 4,
    parameter int                CODE_W          = 4,
    parameter logic [CODE_W-1:0] NOP_CODE        = 4'b0111,
    parameter logic [15:0]       BUBBLE_CNT_INIT = 16'h0000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               id_valid,
    input  logic [CODE_W-1:0]  id_code,
    input  logic [RADDR_W-1:0] id_rs_a,
    input  logic [RADDR_W-1:0] id_rs_b,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]  id_data_a,
    input  logic [DATA_W-1:0]  id_data_b,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_use_imm,
    input  logic               id_wr_en,
    input  logic               id_is_load,
    input  logic               exm_wr_en,
    input  logic               exm_is_load,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic [DATA_W-1:0]  exm_res,
    input  logic               wb_wr_en,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    input  logic               hold,
    output logic [DATA_W-1:0]  OpA,
    output logic [DATA_W-1:0]  OpB,
    output logic [CODE_W-1:0]  CodeULA,
    output logic               ex_valid,
    output logic               ex_wr_en,
    output logic               ex_is_load,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               stall_id,
    output logic [15:0]        bubble_cnt
);

    logic               validQ;
    logic [CODE_W-1:0]  codeQ;
    logic [RADDR_W-1:0] rsAQ;
    logic [RADDR_W-1:0] rsBQ;
    logic [RADDR_W-1:0] rdQ;
    logic [DATA_W-1:0]  dataAQ;
    logic [DATA_W-1:0]  dataBQ;
    logic [DATA_W-1:0]  immQ;
    logic               useImmQ;
    logic               wrEnQ;
    logic               isLoadQ;
    logic [15:0]        bubbleCntQ;

    logic               loadUse;
    logic               insertBubble;
    logic [DATA_W-1:0]  captureA;
    logic [DATA_W-1:0]  captureB;
    logic [DATA_W-1:0]  fwdA;
    logic [DATA_W-1:0]  fwdB;

    // A load in EX cannot forward its data yet, so a dependent instruction in ID waits one cycle.
    assign loadUse = id_valid && validQ && isLoadQ && wrEnQ && (rdQ != '0) &&
                     ((rdQ == id_rs_a) || ((rdQ == id_rs_b) && !id_use_imm));

    assign stall_id     = loadUse || hold;
    assign insertBubble = RST || flush || (!hold && (loadUse || !id_valid));

    // The register file is read in the same cycle it is written, so catch that value here.
    assign captureA = (wb_wr_en && (wb_rd != '0) && (wb_rd == id_rs_a)) ? wb_data : id_data_a;
    assign captureB = (wb_wr_en && (wb_rd != '0) && (wb_rd == id_rs_b)) ? wb_data : id_data_b;

    always_ff @(posedge CLK) begin
        if (insertBubble) begin
            validQ  <= 1'b0;
            codeQ   <= NOP_CODE;
            rsAQ    <= '0;
            rsBQ    <= '0;
            rdQ     <= '0;
            dataAQ  <= '0;
            dataBQ  <= '0;
            immQ    <= '0;
            useImmQ <= 1'b0;
            wrEnQ   <= 1'b0;
            isLoadQ <= 1'b0;
        end else if (!hold) begin
            validQ  <= 1'b1;
            codeQ   <= id_code;
            rsAQ    <= id_rs_a;
            rsBQ    <= id_rs_b;
            rdQ     <= id_rd;
            dataAQ  <= captureA;
            dataBQ  <= captureB;
            immQ    <= id_imm;
            useImmQ <= id_use_imm;
            wrEnQ   <= id_wr_en;
            isLoadQ <= id_is_load;
        end
    end

    // Only bubbles that actually replace a load-use dependent are counted; flush and hold mask them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bubbleCntQ <= BUBBLE_CNT_INIT;
        end else if (!flush && !hold && loadUse && (bubbleCntQ != 16'hFFFF)) begin
            bubbleCntQ <= bubbleCntQ + 16'd1;
        end
    end

    // EX/MEM is newer than MEM/WB and wins; EX/MEM loads have no result yet.
    always_comb begin
        fwdA = dataAQ;
        fwdB = dataBQ;
        if (exm_wr_en && !exm_is_load && (exm_rd != '0) && (exm_rd == rsAQ)) begin
            fwdA = exm_res;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == rsAQ)) begin
            fwdA = wb_data;
        end
        if (exm_wr_en && !exm_is_load && (exm_rd != '0) && (exm_rd == rsBQ)) begin
            fwdB = exm_res;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == rsBQ)) begin
            fwdB = wb_data;
        end
    end

    assign OpA        = fwdA;
    assign OpB        = useImmQ ? immQ : fwdB;
    assign CodeULA    = codeQ;
    assign ex_valid   = validQ;
    assign ex_wr_en   = wrEnQ;
    assign ex_is_load = isLoadQ;
    assign ex_rd      = rdQ;
    assign bubble_cnt = bubbleCntQ;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; a second instance starts its bubble counter near saturation.
module tb_id_ex_operand_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        idValid;
    logic [3:0]  idCode;
    logic [3:0]  idRsA;
    logic [3:0]  idRsB;
    logic [3:0]  idRd;
    logic [15:0] idDataA;
    logic [15:0] idDataB;
    logic [15:0] idImm;
    logic        idUseImm;
    logic        idWrEn;
    logic        idIsLoad;
    logic        exmWrEn;
    logic        exmIsLoad;
    logic [3:0]  exmRd;
    logic [15:0] exmRes;
    logic        wbWrEn;
    logic [3:0]  wbRd;
    logic [15:0] wbData;
    logic        flush;
    logic        hold;

    logic [15:0] opA;
    logic [15:0] opB;
    logic [3:0]  codeUla;
    logic        exValid;
    logic        exWrEn;
    logic        exIsLoad;
    logic [3:0]  exRd;
    logic        stallId;
    logic [15:0] bubbleCnt;

    logic [15:0] satOpA;
    logic [15:0] satOpB;
    logic [3:0]  satCode;
    logic        satValid;
    logic        satWrEn;
    logic        satIsLoad;
    logic [3:0]  satRd;
    logic        satStall;
    logic [15:0] satCnt;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clock = ~clock;

    id_ex_operand_stage dut (
        .CLK(clock), .RST(reset),
        .id_valid(idValid), .id_code(idCode), .id_rs_a(idRsA), .id_rs_b(idRsB), .id_rd(idRd),
        .id_data_a(idDataA), .id_data_b(idDataB), .id_imm(idImm), .id_use_imm(idUseImm),
        .id_wr_en(idWrEn), .id_is_load(idIsLoad),
        .exm_wr_en(exmWrEn), .exm_is_load(exmIsLoad), .exm_rd(exmRd), .exm_res(exmRes),
        .wb_wr_en(wbWrEn), .wb_rd(wbRd), .wb_data(wbData),
        .flush(flush), .hold(hold),
        .OpA(opA), .OpB(opB), .CodeULA(codeUla),
        .ex_valid(exValid), .ex_wr_en(exWrEn), .ex_is_load(exIsLoad), .ex_rd(exRd),
        .stall_id(stallId), .bubble_cnt(bubbleCnt)
    );

    id_ex_operand_stage #(.BUBBLE_CNT_INIT(16'hFFFE)) satDut (
        .CLK(clock), .RST(reset),
        .id_valid(idValid), .id_code(idCode), .id_rs_a(idRsA), .id_rs_b(idRsB), .id_rd(idRd),
        .id_data_a(idDataA), .id_data_b(idDataB), .id_imm(idImm), .id_use_imm(idUseImm),
        .id_wr_en(idWrEn), .id_is_load(idIsLoad),
        .exm_wr_en(exmWrEn), .exm_is_load(exmIsLoad), .exm_rd(exmRd), .exm_res(exmRes),
        .wb_wr_en(wbWrEn), .wb_rd(wbRd), .wb_data(wbData),
        .flush(flush), .hold(hold),
        .OpA(satOpA), .OpB(satOpB), .CodeULA(satCode),
        .ex_valid(satValid), .ex_wr_en(satWrEn), .ex_is_load(satIsLoad), .ex_rd(satRd),
        .stall_id(satStall), .bubble_cnt(satCnt)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] code, input logic [3:0] rsA,
                                 input logic [3:0] rsB, input logic [3:0] rd,
                                 input logic [15:0] dA, input logic [15:0] dB,
                                 input logic [15:0] imm, input logic useImm,
                                 input logic wrEn, input logic isLoad);
        idValid = v; idCode = code; idRsA = rsA; idRsB = rsB; idRd = rd;
        idDataA = dA; idDataB = dB; idImm = imm; idUseImm = useImm;
        idWrEn = wrEn; idIsLoad = isLoad;
    endtask

    task automatic idleId();
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleBack();
        exmWrEn = 1'b0; exmIsLoad = 1'b0; exmRd = 4'h0; exmRes = 16'h0;
        wbWrEn = 1'b0; wbRd = 4'h0; wbData = 16'h0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // LOAD r4 into EX, then an instruction reading r4 forces one bubble.
    task automatic loadUseHazard();
        applyStimulus(1'b1, 4'h1, 4'h0, 4'h0, 4'h4, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'h2, 4'h4, 4'h6, 4'h5, 16'h1111, 16'h0022, 16'h0, 1'b0, 1'b1, 1'b0);
        tick();
        idleId();
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        idleId();
        idleBack();
        #1;
        tick();
        tick();
        checkOutput("reset OpA", opA, 16'h0000);
        checkOutput("reset OpB", opB, 16'h0000);
        checkOutput("reset CodeULA", {12'h0, codeUla}, 16'h0007);
        checkOutput("reset ex_valid", {15'h0, exValid}, 16'h0);
        checkOutput("reset stall_id", {15'h0, stallId}, 16'h0);
        checkOutput("reset bubble_cnt", bubbleCnt, 16'h0000);
        reset = 1'b0;

        // ADD r1 = r2 + r3
        applyStimulus(1'b1, 4'h0, 4'h2, 4'h3, 4'h1, 16'h0005, 16'h0007, 16'h0, 1'b0, 1'b1, 1'b0);
        tick();
        idleId();
        #1;
        checkOutput("add OpA", opA, 16'h0005);
        checkOutput("add OpB", opB, 16'h0007);
        checkOutput("add CodeULA", {12'h0, codeUla}, 16'h0000);
        checkOutput("add ex_rd", {12'h0, exRd}, 16'h0001);
        checkOutput("add ex_valid", {15'h0, exValid}, 16'h1);

        exmWrEn = 1'b1; exmRd = 4'h2; exmRes = 16'h00FF;
        wbWrEn = 1'b1; wbRd = 4'h2; wbData = 16'h1234;
        #1;
        checkOutput("fwd exm priority", opA, 16'h00FF);
        exmWrEn = 1'b0;
        #1;
        checkOutput("fwd wb", opA, 16'h1234);
        exmWrEn = 1'b1; exmIsLoad = 1'b1;
        #1;
        checkOutput("fwd exm load skipped", opA, 16'h1234);
        exmIsLoad = 1'b0; exmRd = 4'h3; wbRd = 4'h9;
        #1;
        checkOutput("fwd exm to OpB", opB, 16'h00FF);
        checkOutput("OpA unforwarded", opA, 16'h0005);
        idleBack();
        tick();

        // Load-use: bubble, then the dependent picks up the load data from MEM/WB
        applyStimulus(1'b1, 4'h1, 4'h0, 4'h0, 4'h4, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("load no stall", {15'h0, stallId}, 16'h0);
        applyStimulus(1'b1, 4'h2, 4'h4, 4'h6, 4'h7, 16'h1111, 16'h0022, 16'h0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("lu stall_id", {15'h0, stallId}, 16'h1);
        tick();
        checkOutput("lu bubble code", {12'h0, codeUla}, 16'h0007);
        checkOutput("lu bubble valid", {15'h0, exValid}, 16'h0);
        checkOutput("lu bubble_cnt", bubbleCnt, 16'h0001);
        checkOutput("lu stall released", {15'h0, stallId}, 16'h0);
        exmWrEn = 1'b1; exmIsLoad = 1'b1; exmRd = 4'h4;
        tick();
        idleId();
        exmWrEn = 1'b0; exmIsLoad = 1'b0; exmRd = 4'h0;
        wbWrEn = 1'b1; wbRd = 4'h4; wbData = 16'hCAFE;
        #1;
        checkOutput("lu dependent OpA", opA, 16'hCAFE);
        checkOutput("lu dependent OpB", opB, 16'h0022);
        checkOutput("lu dependent code", {12'h0, codeUla}, 16'h0002);
        idleBack();
        tick();

        loadUseHazard();
        loadUseHazard();
        checkOutput("cnt before flush", bubbleCnt, 16'h0003);

        // Flush together with a load-use hazard
        applyStimulus(1'b1, 4'h1, 4'h0, 4'h0, 4'h4, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'h2, 4'h4, 4'h6, 4'h5, 16'h1111, 16'h0022, 16'h0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("flush lu stall", {15'h0, stallId}, 16'h1);
        tick();
        flush = 1'b0;
        checkOutput("flush bubble code", {12'h0, codeUla}, 16'h0007);
        checkOutput("flush bubble valid", {15'h0, exValid}, 16'h0);
        checkOutput("flush cnt", bubbleCnt, 16'h0003);

        // Hold with a load-use hazard pending keeps the load in EX
        applyStimulus(1'b1, 4'h3, 4'h8, 4'h9, 4'h4, 16'h0AAA, 16'h0BBB, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'h2, 4'h4, 4'h6, 4'h5, 16'h1111, 16'h0022, 16'h0, 1'b0, 1'b1, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("hold%0d OpA", i), opA, 16'h0AAA);
            checkOutput($sformatf("hold%0d code", i), {12'h0, codeUla}, 16'h0003);
            checkOutput($sformatf("hold%0d is_load", i), {15'h0, exIsLoad}, 16'h1);
            checkOutput($sformatf("hold%0d stall", i), {15'h0, stallId}, 16'h1);
            checkOutput($sformatf("hold%0d cnt", i), bubbleCnt, 16'h0003);
        end
        hold = 1'b0;
        #1;
        checkOutput("post hold lu stall", {15'h0, stallId}, 16'h1);
        tick();
        checkOutput("post hold bubble", {12'h0, codeUla}, 16'h0007);
        checkOutput("post hold cnt", bubbleCnt, 16'h0004);

        // Write-back bypass into the captured register values
        applyStimulus(1'b1, 4'h5, 4'h2, 4'h3, 4'h6, 16'h0001, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b0);
        wbWrEn = 1'b1; wbRd = 4'h2; wbData = 16'h7777;
        tick();
        idleBack();
        idleId();
        #1;
        checkOutput("wb bypass OpA", opA, 16'h7777);
        checkOutput("wb bypass OpB", opB, 16'h0003);

        // Register 0 never forwards; immediate overrides rs_b forwarding
        applyStimulus(1'b1, 4'h1, 4'h0, 4'h5, 4'h6, 16'h0000, 16'h0055, 16'hFFF0, 1'b1, 1'b1, 1'b0);
        tick();
        idleId();
        exmWrEn = 1'b1; exmRd = 4'h0; exmRes = 16'hBEEF;
        wbWrEn = 1'b1; wbRd = 4'h0; wbData = 16'h1234;
        #1;
        checkOutput("r0 no fwd OpA", opA, 16'h0000);
        checkOutput("imm OpB", opB, 16'hFFF0);
        exmRd = 4'h5;
        #1;
        checkOutput("imm beats fwd OpB", opB, 16'hFFF0);
        idleBack();

        // Saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rereset cnt", bubbleCnt, 16'h0000);
        checkOutput("sat init cnt", satCnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) loadUseHazard();
        checkOutput("cnt after 3", bubbleCnt, 16'h0003);
        checkOutput("sat cnt", satCnt, 16'hFFFF);
        tick();
        checkOutput("sat cnt holds", satCnt, 16'hFFFF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage of the 16-bit pipelined core, directly upstream of the ALU. It captures decoded instructions and register-file reads, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and inserts load-use bubbles. It then drives OpA, OpB and CodeULA into the ALU. It also handles flush on taken branches and hold from later stages, and keeps a saturating bubble counter.

## Interface
- DATA_W, 16, operand/result width
- RADDR_W, 4, register address width; register 0 is hardwired zero
- CODE_W, 4, ALU operation code width
- NOP_CODE, 4'b0111, code driven for bubbles/reset
- CLK  in  1  rising-edge clock (single clock domain)
- RST  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_code  in  CODE_W  ALU operation code
- id_rs_a, id_rs_b  in  RADDR_W  source register addresses
- id_rd  in  RADDR_W  destination register
- id_data_a, id_data_b  in  DATA_W  register-file read values
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  OpB comes from immediate, not rs_b
- id_wr_en, id_is_load  in  1  writes rd / is a memory load
- exm_wr_en, exm_is_load  in  1  EX/MEM instruction writes rd / is load
- exm_rd  in  RADDR_W;  exm_res  in  DATA_W  EX/MEM destination and registered ALU result
- wb_wr_en  in  1;  wb_rd  in  RADDR_W;  wb_data  in  DATA_W  write-back port
- flush  in  1  taken branch: kill instruction entering EX
- hold  in  1  downstream stall: freeze ID/EX
- OpA, OpB  out  DATA_W  ALU operands (after forwarding)
- CodeULA  out  CODE_W  ALU operation code
- ex_valid, ex_wr_en, ex_is_load  out  1  EX-stage control, passed to EX/MEM
- ex_rd  out  RADDR_W  EX-stage destination
- stall_id  out  1  decode/fetch must hold current instruction
- bubble_cnt  out  16  load-use bubbles inserted, saturating

## Operation
- Registered state (ID/EX): valid, code, rs_a, rs_b, rd, data_a, data_b, imm, use_imm, wr_en, is_load.
- Bubble = valid 0, code NOP_CODE, wr_en 0, is_load 0, rd 0, data 0.
- Reset: all ID/EX fields take bubble values, bubble_cnt = 0. Outputs then read OpA = 0, OpB = 0, CodeULA = 0111, ex_* = 0, stall_id = 0.
- Load-use hazard (combinational): lu = id_valid & valid & is_load & wr_en & rd≠0 & (rd==id_rs_a | (rd==id_rs_b & ~id_use_imm)).
- stall_id = lu | hold.
- Per-edge update, priority order:
  - RST: bubble.
  - flush: bubble. This wins over hold and lu.
  - hold: retain all fields.
  - lu: load a bubble and increment bubble_cnt, saturating at 16'hFFFF.
  - otherwise: capture ID inputs. If id_valid = 0, capture a bubble.
- Write-back bypass at capture: if wb_wr_en & wb_rd≠0 & wb_rd==id_rs_a, capture wb_data as data_a. The same rule applies to rs_b / data_b. This covers the register-file read-during-write case.
- Forwarding (combinational, EX stage), per source s ∈ {a, b}:
  - If exm_wr_en & ~exm_is_load & exm_rd≠0 & exm_rd==rs_s: use exm_res.
  - Else if wb_wr_en & wb_rd≠0 & wb_rd==rs_s: use wb_data.
  - Else: use data_s.
- OpA = fwd_a. OpB = use_imm ? imm : fwd_b.
- CodeULA = code. For BEZ, OpA is the zero-tested value and OpB is the target; both are forwarded like any other operand.
- Register 0 is never forwarded and never causes a hazard.

## Timing
- Latency: ID inputs sampled at edge N appear on OpA/OpB/CodeULA in cycle N+1.
- Forwarding paths exm_*/wb_* → OpA/OpB are combinational within the same cycle.
- stall_id is combinational from ID/EX state, ID inputs and hold. It is valid in the same cycle.
- Load-use: exactly one bubble per hazard. On the next cycle the load is in EX/MEM, and its data reaches the instruction through the MEM/WB forward.
- Flush and lu in the same cycle: a bubble is inserted and bubble_cnt does not increment.
- hold and lu in the same cycle: the state is retained and bubble_cnt does not increment.
- Reset asserted mid-stall: bubble on the next edge, and stall_id falls once RST has cleared the state and hold = 0.
- bubble_cnt at 16'hFFFF stays at 16'hFFFF.

## Test plan
- Reset, then capture ADD r1 = r2 + r3 (data 5, 7) -> after RST the outputs are OpA 0, CodeULA 0111, ex_valid 0. One cycle after capture: OpA 5, OpB 7, CodeULA 0000, ex_rd 1.
- EX/MEM r2 = 0x00FF and MEM/WB r2 = 0x1234, EX reads r2 -> OpA 0x00FF (EX/MEM priority). Drop exm_wr_en -> OpA 0x1234.
- EX holds LOAD r4, ID reads r4 -> stall_id 1 for one cycle, a bubble (CodeULA 0111) enters EX, bubble_cnt goes 0→1. Next cycle OpA = wb_data.
- flush and lu together with bubble_cnt = 3 -> bubble enters EX, bubble_cnt stays 3. With hold = 1 the ID/EX contents are unchanged for 3 cycles and stall_id = 1.
- rs_a = 0 while exm_rd = 0, exm_wr_en = 1, exm_res = 0xBEEF -> OpA = captured data_a (0). Also, with use_imm and imm = 0xFFF0, OpB = 0xFFF0 regardless of rs_b forwarding.
- Force bubble_cnt to 0xFFFE and trigger 3 load-use hazards -> bubble_cnt reads 0xFFFF and holds.
